// File: rtl/nios_dbg_scan_cmd_queue.sv
// Debug scan path: capture/shift DR register and queue {IR, DR} commands into a small FIFO for the core.
// Optional DBG_SCAN_PARITY_EN adds an even-parity bit above the DR and rejects commands that fail it.
module nios_dbg_scan_cmd_queue #(
  parameter int IR_W      = 2,
  parameter int DR_W      = 38,
  parameter int CMD_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [IR_W-1:0]                scan_ir,
  input  logic                           scan_capture,
  input  logic                           scan_shift,
  input  logic                           scan_update,
  input  logic                           scan_tdi,
  output logic                           scan_tdo,
  input  logic [DR_W-1:0]                capture_data,
  output logic                           cmd_valid,
  input  logic                           cmd_ready,
  output logic [IR_W-1:0]                cmd_op,
  output logic [DR_W-1:0]                cmd_data,
  output logic [$clog2(CMD_DEPTH):0]     cmd_count,
  output logic                           overrun,
  output logic                           parity_err,
  input  logic                           clr_sticky
);
  localparam int PW = $clog2(CMD_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = IR_W + DR_W;
`ifdef DBG_SCAN_PARITY_EN
  localparam int SRW = DR_W + 1;
`else
  localparam int SRW = DR_W;
`endif

  typedef enum logic [1:0] {IDLE, CAPD, SHIFTING} state_t;

  state_t                       state_q, state_d;
  logic [SRW-1:0]               sr_q, sr_d;
  logic [CMD_DEPTH-1:0][EW-1:0] mem_q, mem_d;
  logic [PW-1:0]                wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]                count_q, count_d;
  logic                         valid_q, valid_d;
  logic [EW-1:0]                head_q, head_d;
  logic                         ovr_q, ovr_d, perr_q, perr_d;

  logic          upd, shf, par_ok, deq, full, enq, ovr_set, perr_set;
  logic [EW-1:0] wdata;
  logic [CW-1:0] remain;

  // Strobe priority: capture > update > shift; a shift before any capture is ignored.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    upd     = scan_update && !scan_capture;
    shf     = scan_shift && !scan_capture && !scan_update && (state_q != IDLE);
    if (scan_capture) begin
`ifdef DBG_SCAN_PARITY_EN
      sr_d = {^capture_data, capture_data};
`else
      sr_d = capture_data;
`endif
      state_d = CAPD;
    end else if (upd) begin
      state_d = IDLE;
    end else if (shf) begin
      sr_d    = {scan_tdi, sr_q[SRW-1:1]};
      state_d = SHIFTING;
    end
  end

  always_comb begin
`ifdef DBG_SCAN_PARITY_EN
    par_ok = ~^{scan_ir, sr_q};
`else
    par_ok = 1'b1;
`endif
    deq      = valid_q && cmd_ready;
    full     = (count_q == CW'(CMD_DEPTH));
    enq      = upd && par_ok && (!full || deq);
    ovr_set  = upd && par_ok && full && !deq;
    perr_set = upd && !par_ok;
    wdata    = {scan_ir, sr_q[DR_W-1:0]};
    mem_d    = mem_q;
    if (enq) mem_d[wr_q] = wdata;
    wr_d    = wr_q + PW'(enq);
    rd_d    = rd_q + PW'(deq);
    count_d = count_q + CW'(enq) - CW'(deq);
    valid_d = (count_d != '0);
    remain  = count_q - CW'(deq);
    // Head register: bypass the write when the queue would otherwise be empty.
    head_d = head_q;
    if (count_d != '0) head_d = (remain == '0) ? wdata : mem_q[rd_d];
    ovr_d  = ovr_set  ? 1'b1 : (clr_sticky ? 1'b0 : ovr_q);
    perr_d = perr_set ? 1'b1 : (clr_sticky ? 1'b0 : perr_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      mem_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      head_q  <= '0;
      ovr_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      ovr_q   <= ovr_d;
      perr_q  <= perr_d;
    end
  end

  assign scan_tdo  = sr_q[0];
  assign cmd_valid = valid_q;
  assign cmd_op    = head_q[EW-1:DR_W];
  assign cmd_data  = head_q[DR_W-1:0];
  assign cmd_count = count_q;
  assign overrun   = ovr_q;
`ifdef DBG_SCAN_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
